xgcd_apb_ctrl: RTL

Parametrised APB control/status front end for the XGCD engine.
- Holds WIDTH-bit operands A and B as 32-bit word registers and launches the engine with a one-cycle START_OUT pulse.
- Captures RESULT_IN and the run's cycle count when the engine raises DONE_IN, and raises a maskable level IRQ.
- Replaces the fixed ID-only register stub; sits between the APB interconnect and the XGCD datapath.

---
 rtl/xgcd_apb_ctrl_if.sv | 24 ++
 rtl/xgcd_apb_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xgcd_apb_ctrl_if.sv
// xgcd_apb_ctrl_if
// APB3 bus bundle between the interconnect and the XGCD control front end.
//   master : drives PADDR, PSEL, PENABLE, PWRITE, PWDATA; samples PRDATA, PREADY, PSLVERR
//   slave  : samples the request signals; drives PRDATA, PREADY, PSLVERR
interface xgcd_apb_ctrl_if;
    logic [31:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/xgcd_apb_ctrl.sv
// xgcd_apb_ctrl
// APB control/status front end for the XGCD engine. Holds the WIDTH-bit
// operands as 32-bit word registers, launches the engine with a one-cycle
// START_OUT pulse, captures RESULT_IN and the run length on DONE_IN, and
// raises a maskable level interrupt.
//
// Ports:
//   CLK        clock, all logic on the rising edge
//   RESETn     synchronous active-low reset
//   apb        APB slave (word offset decoded from PADDR[11:2], PREADY tied 1)
//   OP_A/OP_B  operand registers to the engine
//   START_OUT  one-cycle launch pulse
//   DONE_IN    engine completion pulse, RESULT_IN valid with it
//   BUSY       high while a run is in progress
//   DONE_OUT   one-cycle pulse when a result is captured
//   IRQ        IRQ_EN & (DONE | ERR)
//
// Register map (word offset): 0 ID, 1 CTRL, 2 STATUS, 3 CYCLES,
// 16.. OPA words, 16+NW.. OPB words, 16+2NW.. RES words.
//
// Optional macro XGCD_TIMEOUT_EN: abort a run that reaches TIMEOUT cycles
// without DONE_IN, setting STATUS.ERR. Without it STATUS.ERR reads 0.
//
// state  | meaning
// -------+-------------------------------------------------
// S_IDLE | engine stopped, waiting for a CTRL.START write
// S_RUN  | engine running, counting cycles until DONE_IN
module xgcd_apb_ctrl #(
    parameter int          WIDTH    = 64,
    parameter logic [31:0] ID_VALUE = 32'h5A5A5A5A,
    parameter int          TIMEOUT  = 4096
) (
    input  logic              CLK,
    input  logic              RESETn,
    xgcd_apb_ctrl_if.slave    apb,
    output logic [WIDTH-1:0]  OP_A,
    output logic [WIDTH-1:0]  OP_B,
    output logic              START_OUT,
    input  logic              DONE_IN,
    input  logic [WIDTH-1:0]  RESULT_IN,
    output logic              BUSY,
    output logic              DONE_OUT,
    output logic              IRQ
);
    localparam int NW = WIDTH / 32;

    localparam logic [9:0] OFF_ID     = 10'd0;
    localparam logic [9:0] OFF_CTRL   = 10'd1;
    localparam logic [9:0] OFF_STATUS = 10'd2;
    localparam logic [9:0] OFF_CYCLES = 10'd3;
    localparam logic [9:0] OPA_BASE   = 10'd16;
    localparam logic [9:0] OPB_BASE   = 10'(16 + NW);
    localparam logic [9:0] RES_BASE   = 10'(16 + 2 * NW);

    if ((WIDTH % 32) != 0 || WIDTH < 32 || WIDTH > 2048 || TIMEOUT < 1) begin : g_bad_param
        $error("xgcd_apb_ctrl: WIDTH must be a multiple of 32 in 32..2048 and TIMEOUT >= 1");
    end

`ifdef XGCD_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LAST   = 32'(TIMEOUT - 1);
    localparam logic [31:0] TIMEOUT_CYCLES = 32'(TIMEOUT);
`endif

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res;
    logic [31:0]      cycles;
    logic [31:0]      run_cnt;
    logic [31:0]      prdata;
    logic [31:0]      rd_data;
    logic             irq_en;
    logic             done;
    logic             err;
    logic             start_q;
    logic             done_q;
    logic             busy;
    logic             launch;
    logic             finish;
`ifdef XGCD_TIMEOUT_EN
    logic             timeout_hit;
`endif

    logic [9:0] off;
    logic       setup;
    logic       access;
    logic       hit_reg;
    logic       hit_opa;
    logic       hit_opb;
    logic       hit_res;
    logic       mapped;
    logic       wr_setup;
    logic       op_wr;
    logic       ctrl_wr;
    logic       status_wr;

    assign off    = apb.PADDR[11:2];
    assign setup  = apb.PSEL & ~apb.PENABLE;
    assign access = apb.PSEL & apb.PENABLE;
    assign busy   = (state == S_RUN);

    // Address decode and read mux; rd_data stays 0 for unmapped offsets.
    always_comb begin
        hit_opa = 1'b0;
        hit_opb = 1'b0;
        hit_res = 1'b0;
        rd_data = '0;
        case (off)
            OFF_ID:     rd_data = ID_VALUE;
            OFF_CTRL:   rd_data = {30'd0, irq_en, 1'b0};
            OFF_STATUS: rd_data = {29'd0, err, done, busy};
            OFF_CYCLES: rd_data = cycles;
            default:    ;
        endcase
        for (int w = 0; w < NW; w++) begin
            if (off == OPA_BASE + 10'(w)) begin
                hit_opa = 1'b1;
                rd_data = opa[w*32 +: 32];
            end
            if (off == OPB_BASE + 10'(w)) begin
                hit_opb = 1'b1;
                rd_data = opb[w*32 +: 32];
            end
            if (off == RES_BASE + 10'(w)) begin
                hit_res = 1'b1;
                rd_data = res[w*32 +: 32];
            end
        end
    end

    assign hit_reg   = (off <= OFF_CYCLES);
    assign mapped    = hit_reg | hit_opa | hit_opb | hit_res;
    assign wr_setup  = setup & apb.PWRITE & mapped;
    // Operand writes during a run would corrupt the engine inputs: dropped and flagged.
    assign op_wr     = wr_setup & (hit_opa | hit_opb) & ~busy;
    assign ctrl_wr   = wr_setup & (off == OFF_CTRL);
    assign status_wr = wr_setup & (off == OFF_STATUS);

    assign apb.PRDATA  = prdata;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = access & (~mapped | (apb.PWRITE & busy & (hit_opa | hit_opb)));

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        finish    = 1'b0;
`ifdef XGCD_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (ctrl_wr && apb.PWDATA[0]) begin
                    state_nxt = S_RUN;
                    launch    = 1'b1;
                end
            end
            S_RUN: begin
                // DONE_IN has priority over a timeout in the same cycle.
                if (DONE_IN) begin
                    state_nxt = S_IDLE;
                    finish    = 1'b1;
                end
`ifdef XGCD_TIMEOUT_EN
                else if (run_cnt == TIMEOUT_LAST) begin
                    state_nxt   = S_IDLE;
                    timeout_hit = 1'b1;
                end
`endif
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state   <= S_IDLE;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            run_cnt <= '0;
            cycles  <= '0;
            prdata  <= '0;
            irq_en  <= 1'b0;
            done    <= 1'b0;
            opa     <= '0;
            opb     <= '0;
            res     <= '0;
        end else begin
            state   <= state_nxt;
            start_q <= launch;
            done_q  <= finish;

            if (launch) begin
                run_cnt <= '0;
            end else if (busy && run_cnt != 32'hFFFF_FFFF) begin
                run_cnt <= run_cnt + 32'd1;
            end

            if (setup && !apb.PWRITE) begin
                prdata <= rd_data;
            end

            if (ctrl_wr) begin
                irq_en <= apb.PWDATA[1];
            end

            if (finish) begin
                res    <= RESULT_IN;
                cycles <= run_cnt;
            end
`ifdef XGCD_TIMEOUT_EN
            else if (timeout_hit) begin
                cycles <= TIMEOUT_CYCLES;
            end
`endif

            // Hardware set beats a simultaneous W1C.
            if (finish) begin
                done <= 1'b1;
            end else if (status_wr && apb.PWDATA[1]) begin
                done <= 1'b0;
            end

            for (int w = 0; w < NW; w++) begin
                if (op_wr && off == OPA_BASE + 10'(w)) begin
                    opa[w*32 +: 32] <= apb.PWDATA;
                end
                if (op_wr && off == OPB_BASE + 10'(w)) begin
                    opb[w*32 +: 32] <= apb.PWDATA;
                end
            end
        end
    end

`ifdef XGCD_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            err <= 1'b0;
        end else if (timeout_hit) begin
            err <= 1'b1;
        end else if (status_wr && apb.PWDATA[2]) begin
            err <= 1'b0;
        end
    end
`else
    assign err = 1'b0;
`endif

    assign OP_A      = opa;
    assign OP_B      = opb;
    assign START_OUT = start_q;
    assign DONE_OUT  = done_q;
    assign BUSY      = busy;
    assign IRQ       = irq_en & (done | err);
endmodule
